mem_port_arbiter: RTL and testbench

//  Shares one downstream memory port between three core-side requesters:

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction read, data read and data write.
// Latency: ACK one cycle after the request, RVALID/WDONE at least 4 cycles after it.
// Backpressure: M_* held stable until M_READY; requests stay pending until their ACK.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    i_rden,
    input  logic [ADDR_WIDTH-1:0]   i_raddr,
    output logic                    i_ack,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_rden,
    input  logic [ADDR_WIDTH-1:0]   d_raddr,
    output logic                    d_ack,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    input  logic                    d_wren,
    input  logic [ADDR_WIDTH-1:0]   d_waddr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_wack,
    output logic                    d_wdone,
    output logic                    m_valid,
    output logic                    m_we,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_strb,
    input  logic                    m_ready,
    input  logic                    m_rvalid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic                    m_bvalid,
    output logic                    busy
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {OWN_I, OWN_DR, OWN_DW} owner_t;

    state_t                 state;
    owner_t                 owner;
    logic [CW-1:0]          starve_cnt;
    logic                   drop;
    logic                   rsp_got;
    logic [DATA_WIDTH-1:0]  rsp_buf;

    logic i_req;
    logic grant_i;
    logic grant_dw;
    logic grant_dr;
    logic inst_flush;

    // A flush in IDLE hides the fetch request so a stale address is never issued.
    always_comb begin
        i_req      = i_rden & ~flush;
        grant_i    = i_req & ((starve_cnt == STARVE_MAX) | ~(d_wren | d_rden));
        grant_dw   = d_wren & ~grant_i;
        grant_dr   = d_rden & ~d_wren & ~grant_i;
        inst_flush = flush & (owner == OWN_I);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_I;
            starve_cnt <= '0;
            drop       <= 1'b0;
            rsp_got    <= 1'b0;
            rsp_buf    <= '0;
            i_ack      <= 1'b0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_ack      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            d_wack     <= 1'b0;
            d_wdone    <= 1'b0;
            m_valid    <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_strb     <= '0;
            busy       <= 1'b0;
        end else begin
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            d_wack   <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            d_wdone  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i | grant_dw | grant_dr) begin
                        state   <= ISSUE;
                        busy    <= 1'b1;
                        m_valid <= 1'b1;
                        drop    <= 1'b0;
                        rsp_got <= 1'b0;
                        if (grant_i)
                            starve_cnt <= '0;
                        else if (i_req && starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + CW'(1);
                        if (grant_dw) begin
                            owner   <= OWN_DW;
                            m_we    <= 1'b1;
                            m_addr  <= d_waddr;
                            m_wdata <= d_wdata;
                            m_strb  <= d_wstrb;
                            d_wack  <= 1'b1;
                        end else if (grant_dr) begin
                            owner   <= OWN_DR;
                            m_we    <= 1'b0;
                            m_addr  <= d_raddr;
                            m_wdata <= '0;
                            m_strb  <= '1;
                            d_ack   <= 1'b1;
                        end else begin
                            owner   <= OWN_I;
                            m_we    <= 1'b0;
                            m_addr  <= i_raddr;
                            m_wdata <= '0;
                            m_strb  <= '1;
                            i_ack   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (inst_flush)
                        drop <= 1'b1;
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (!rsp_got) begin
                        if (inst_flush)
                            drop <= 1'b1;
                        if (!m_we && m_rvalid) begin
                            rsp_buf <= m_rdata;
                            rsp_got <= 1'b1;
                        end else if (m_we && m_bvalid) begin
                            rsp_got <= 1'b1;
                        end
                    end else begin
                        // Response captured last cycle: hand it to the owner and release the port.
                        state   <= IDLE;
                        busy    <= 1'b0;
                        drop    <= 1'b0;
                        rsp_got <= 1'b0;
                        case (owner)
                            OWN_I: begin
                                if (!(drop || flush)) begin
                                    i_rvalid <= 1'b1;
                                    i_rdata  <= rsp_buf;
                                end
                            end
                            OWN_DR: begin
                                d_rvalid <= 1'b1;
                                d_rdata  <= rsp_buf;
                            end
                            default: d_wdone <= 1'b1;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions plus hand-written arbitration,
// flush and reset sequences; completions are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int K_I  = 0;
    localparam int K_DR = 1;
    localparam int K_DW = 2;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        i_rden, i_ack, i_rvalid;
    logic [31:0] i_raddr, i_rdata;
    logic        d_rden, d_ack, d_rvalid;
    logic [31:0] d_raddr, d_rdata;
    logic        d_wren, d_wack, d_wdone;
    logic [31:0] d_waddr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        m_valid, m_we, m_ready, m_rvalid, m_bvalid, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_strb;

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          rdly;
        int          sdly;
        logic [31:0] rdata;
    } vec_t;
    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } hs_t;

    exp_t        sb[$];
    hs_t         hs_log[$];
    int          total = 0;
    int          bad = 0;
    int          ready_dly = 0;
    int          resp_dly = 0;
    logic [31:0] resp_data = '0;
    logic [31:0] last_i_data = '0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .i_rden(i_rden), .i_raddr(i_raddr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_rden(d_rden), .d_raddr(d_raddr), .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_wren(d_wren), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_wack(d_wack), .d_wdone(d_wdone),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_strb(m_strb),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_bvalid(m_bvalid),
        .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata, d_wack, d_wdone,
                 m_valid, m_we, m_addr, m_wdata, m_strb, busy};
    endfunction

    function automatic logic ack_of(input int k);
        return (k == K_I) ? i_ack : (k == K_DR) ? d_ack : d_wack;
    endfunction

    function automatic logic done_of(input int k);
        return (k == K_I) ? i_rvalid : (k == K_DR) ? d_rvalid : d_wdone;
    endfunction

    task automatic sb_pop(input int k, input logic [31:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: completion kind %0d with nothing pending", k);
        end else begin
            e = sb.pop_front();
            check("sb_kind", 64'(k), 64'(e.kind));
            if (k != K_DW) check("sb_data", {32'h0, d}, {32'h0, e.data});
        end
    endtask

    // Downstream model: M_READY after ready_dly wait cycles, response resp_dly cycles after the handshake.
    int   vcnt = 0, rcnt = 0;
    logic pend = 1'b0, pend_we = 1'b0;
    initial begin
        hs_t h;
        m_ready = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0; m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && m_valid && m_ready) begin
                h.we = m_we; h.addr = m_addr; h.wdata = m_wdata; h.strb = m_strb;
                hs_log.push_back(h);
                pend = 1'b1; pend_we = m_we; rcnt = resp_dly;
            end
            step();
            m_rvalid = 1'b0;
            m_bvalid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0; m_ready = 1'b0; vcnt = 0;
            end else begin
                if (pend) begin
                    if (rcnt == 0) begin
                        pend = 1'b0;
                        if (pend_we) m_bvalid = 1'b1;
                        else begin m_rvalid = 1'b1; m_rdata = resp_data; end
                    end else rcnt--;
                end
                if (m_valid) begin m_ready = (vcnt >= ready_dly); vcnt++; end
                else begin m_ready = 1'b0; vcnt = 0; end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i_rvalid) sb_pop(K_I, i_rdata);
                if (d_rvalid) sb_pop(K_DR, d_rdata);
                if (d_wdone)  sb_pop(K_DW, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drop_reqs();
        i_rden = 1'b0; d_rden = 1'b0; d_wren = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e;
        hs_t  h;
        int   ack_c, done_c, vcyc;
        logic stable, busy_done;
        hs_log.delete();
        resp_data = v.rdata; ready_dly = v.rdly; resp_dly = v.sdly;
        step();
        case (v.kind)
            K_I:  begin i_rden = 1'b1; i_raddr = v.addr; end
            K_DR: begin d_rden = 1'b1; d_raddr = v.addr; end
            default: begin d_wren = 1'b1; d_waddr = v.addr; d_wdata = v.wdata; d_wstrb = v.strb; end
        endcase
        e.kind = v.kind; e.data = (v.kind == K_DW) ? 32'h0 : v.rdata;
        sb.push_back(e);
        ack_c = -1; done_c = -1; vcyc = 0; stable = 1'b1; busy_done = 1'b1;
        for (int c = 0; c < 60 && done_c < 0; c++) begin
            @(negedge clk);
            if (m_valid) begin
                vcyc++;
                if (m_addr != v.addr || m_we != (v.kind == K_DW)) stable = 1'b0;
                if (v.kind == K_DW && m_wdata != v.wdata) stable = 1'b0;
            end
            if (ack_c < 0 && ack_of(v.kind)) ack_c = c;
            if (done_of(v.kind)) begin done_c = c; busy_done = busy; end
            step();
            if (ack_c >= 0) drop_reqs();
        end
        check("ack_cycle", 64'(ack_c), 64'd1);
        check("done_cycle", 64'(done_c), 64'(4 + v.rdly + v.sdly));
        check("valid_cycles", 64'(vcyc), 64'(v.rdly + 1));
        check("m_stable", {63'h0, stable}, 64'd1);
        check("busy_at_done", {63'h0, busy_done}, 64'd0);
        check("hs_count", 64'(hs_log.size()), 64'd1);
        if (hs_log.size() > 0) begin
            h = hs_log.pop_front();
            check("hs_addr", {32'h0, h.addr}, {32'h0, v.addr});
            check("hs_we", {63'h0, h.we}, {63'h0, v.kind == K_DW});
            check("hs_strb", {60'h0, h.strb}, (v.kind == K_DW) ? {60'h0, v.strb} : 64'hF);
            if (v.kind == K_DW) check("hs_wdata", {32'h0, h.wdata}, {32'h0, v.wdata});
        end
        if (v.kind == K_I) last_i_data = v.rdata;
    endtask

    initial begin
        vec_t vecs[6];
        exp_t e;
        int   wack_c, wdone_c, iack_c, irv_c, n_d, idle_c;
        logic iack, idone, saw_rv, got;

        vecs[0] = '{K_I,  32'h100,      32'h0,        4'h0, 0, 0, 32'h00000013};
        vecs[1] = '{K_DR, 32'h104,      32'h0,        4'h0, 1, 2, 32'hCAFEF00D};
        vecs[2] = '{K_DW, 32'h200,      32'hDEADBEEF, 4'hF, 0, 0, 32'h0};
        vecs[3] = '{K_DW, 32'h208,      32'h12345678, 4'h3, 5, 1, 32'h0};
        vecs[4] = '{K_I,  32'hFFFFFFFC, 32'h0,        4'h0, 0, 3, 32'hA5A5A5A5};
        vecs[5] = '{K_DR, 32'h0,        32'h0,        4'h0, 2, 0, 32'hFFFFFFFF};

        rst_n = 1'b0; flush = 1'b0;
        i_rden = 1'b0; i_raddr = '0; d_rden = 1'b0; d_raddr = '0;
        d_wren = 1'b0; d_waddr = '0; d_wdata = '0; d_wstrb = '0;
        repeat (3) step();
        check("reset_outs", {63'h0, any_out()}, 64'd0);
        check("reset_busy", {63'h0, busy}, 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Write and fetch together: write first, fetch granted only after the write completes.
        hs_log.delete(); ready_dly = 0; resp_dly = 0; resp_data = 32'h0BADC0DE;
        step();
        d_wren = 1'b1; d_waddr = 32'h200; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        i_rden = 1'b1; i_raddr = 32'h400;
        e.kind = K_DW; e.data = 32'h0;        sb.push_back(e);
        e.kind = K_I;  e.data = 32'h0BADC0DE; sb.push_back(e);
        wack_c = -1; wdone_c = -1; iack_c = -1; irv_c = -1;
        for (int c = 0; c < 40 && irv_c < 0; c++) begin
            @(negedge clk);
            if (d_wack && wack_c < 0) wack_c = c;
            if (d_wdone) wdone_c = c;
            if (i_ack && iack_c < 0) iack_c = c;
            if (i_rvalid) irv_c = c;
            step();
            if (wack_c >= 0) d_wren = 1'b0;
            if (iack_c >= 0) i_rden = 1'b0;
        end
        check("prio_wack", 64'(wack_c), 64'd1);
        check("prio_wdone", 64'(wdone_c), 64'd4);
        check("prio_iack", 64'(iack_c), 64'd5);
        check("prio_irvalid", 64'(irv_c), 64'd8);
        check("prio_hs_count", 64'(hs_log.size()), 64'd2);
        if (hs_log.size() == 2) begin
            check("prio_first_we", {63'h0, hs_log[0].we}, 64'd1);
            check("prio_first_wdata", {32'h0, hs_log[0].wdata}, 64'hDEADBEEF);
            check("prio_second_addr", {32'h0, hs_log[1].addr}, 64'h400);
        end
        last_i_data = 32'h0BADC0DE;

        // Starvation: data reads keep winning until the fetch has lost 8 rounds.
        hs_log.delete(); resp_data = 32'h5;
        e.kind = K_DR; e.data = 32'h5;
        for (int i = 0; i < 8; i++) sb.push_back(e);
        e.kind = K_I; sb.push_back(e);
        step();
        d_rden = 1'b1; d_raddr = 32'h600; i_rden = 1'b1; i_raddr = 32'h700;
        n_d = 0; iack = 1'b0; idone = 1'b0;
        for (int c = 0; c < 400 && !idone; c++) begin
            @(negedge clk);
            if (d_ack && !iack) n_d++;
            if (i_ack) iack = 1'b1;
            if (i_rvalid) idone = 1'b1;
            step();
            if (iack) drop_reqs();
        end
        check("starve_data_wins", 64'(n_d), 64'd8);
        check("starve_inst_done", {63'h0, idone}, 64'd1);
        check("starve_hs_count", 64'(hs_log.size()), 64'd9);
        if (hs_log.size() == 9) check("starve_last_addr", {32'h0, hs_log[8].addr}, 64'h700);
        last_i_data = 32'h5;

        // Flush one cycle after the fetch ACK: response is dropped and the port frees up.
        hs_log.delete(); ready_dly = 0; resp_dly = 2; resp_data = 32'h99;
        step();
        i_rden = 1'b1; i_raddr = 32'h300;
        iack_c = -1; idle_c = -1; saw_rv = 1'b0;
        for (int c = 0; c < 30 && idle_c < 0; c++) begin
            @(negedge clk);
            if (i_ack && iack_c < 0) iack_c = c;
            if (i_rvalid) saw_rv = 1'b1;
            if (iack_c >= 0 && c > iack_c && !busy) idle_c = c;
            step();
            if (iack_c >= 0) i_rden = 1'b0;
            flush = (iack_c >= 0 && c == iack_c);
        end
        flush = 1'b0;
        check("flush_iack", 64'(iack_c), 64'd1);
        check("flush_idle_cycle", 64'(idle_c), 64'd6);
        check("flush_no_rvalid", {63'h0, saw_rv}, 64'd0);
        check("flush_rdata_kept", {32'h0, i_rdata}, {32'h0, last_i_data});
        check("flush_hs_count", 64'(hs_log.size()), 64'd1);
        run_txn('{K_DR, 32'h304, 32'h0, 4'h0, 0, 0, 32'h12345678});

        // Reset asserted mid-transaction while waiting for the response.
        hs_log.delete(); ready_dly = 0; resp_dly = 10;
        step();
        i_rden = 1'b1; i_raddr = 32'h500;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (i_ack) got = 1'b1;
            step();
        end
        i_rden = 1'b0;
        check("rst_seq_ack", {63'h0, got}, 64'd1);
        step();
        @(negedge clk);
        check("rst_pre_busy", {63'h0, busy}, 64'd1);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_outs", {63'h0, any_out()}, 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        hs_log.delete();
        last_i_data = '0;
        run_txn('{K_I, 32'h504, 32'h0, 4'h0, 0, 0, 32'hFEEDFACE});

        repeat (3) step();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
